// File: rtl/iir_block_sequencer.sv
// Block sequencer for the free-running IIR filter datapath: optional state clear,
// streams len samples from dataX into the filter and captures results into dataY.
module iir_block_sequencer #(
   parameter int DW           = 32,
   parameter int NSAMP        = 32,
   parameter int AW           = 5,
   parameter int PIPE_LAT     = 8,
   parameter int CLR_ON_START = 1
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          start_i,
   input  logic          abort_i,
   input  logic [AW:0]   len_i,
   output logic [AW-1:0] x_rd_addr_o,
   input  logic [DW-1:0] x_rd_data_i,
   output logic [DW-1:0] filt_in_o,
   output logic          filt_clr_o,
   input  logic [DW-1:0] filt_out_i,
   output logic          y_wr_en_o,
   output logic [AW-1:0] y_wr_addr_o,
   output logic [DW-1:0] y_wr_data_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          aborted_o,
   output logic          ovr_o,
   output logic          int_o
);

   localparam int LW = $clog2(PIPE_LAT + 1);
   localparam logic [LW-1:0] LAT_MAX  = LW'(PIPE_LAT);
   localparam logic [LW-1:0] LAT_ONE  = LW'(1);
   localparam logic [AW:0]   NSAMP_W  = (AW+1)'(NSAMP);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [AW:0]   len_q, len_d;
   logic [AW:0]   feed_cnt_q, feed_cnt_d;
   logic [AW:0]   cap_cnt_q, cap_cnt_d;
   logic [LW-1:0] lat_cnt_q, lat_cnt_d;
   logic          done_q, done_d;
   logic          aborted_q, aborted_d;
   logic          ovr_q, ovr_d;

   logic          in_feed_s;
   logic          in_cap_s;
   logic          cap_act_s;
   logic          wr_fire_s;

   // Capture window decode; abort blocks the write in the same cycle it arrives
   always_comb begin
      in_feed_s = (state_q == ST_FEED);
      in_cap_s  = (state_q == ST_FEED) || (state_q == ST_DRAIN);
      cap_act_s = in_cap_s && (lat_cnt_q == LAT_MAX) && (cap_cnt_q < len_q);
      wr_fire_s = cap_act_s && !abort_i;
   end

   // Next-state, counter and sticky-flag computation
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      feed_cnt_d = feed_cnt_q;
      cap_cnt_d  = cap_cnt_q;
      lat_cnt_d  = lat_cnt_q;
      done_d     = done_q;
      aborted_d  = aborted_q;
      ovr_d      = ovr_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i && !abort_i) begin
               if ((len_i == CNT_ZERO) || (len_i > NSAMP_W)) begin
                  len_d = NSAMP_W;
               end else begin
                  len_d = len_i;
               end
               done_d     = 1'b0;
               aborted_d  = 1'b0;
               ovr_d      = 1'b0;
               feed_cnt_d = CNT_ZERO;
               cap_cnt_d  = CNT_ZERO;
               lat_cnt_d  = {LW{1'b0}};
               state_d    = (CLR_ON_START != 0) ? ST_CLR : ST_FEED;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLR: begin
            state_d = ST_FEED;
         end
         ST_FEED: begin
            feed_cnt_d = feed_cnt_q + CNT_ONE;
            if (feed_cnt_q == (len_q - CNT_ONE)) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_FEED;
            end
         end
         ST_DRAIN: begin
            if (cap_act_s && (cap_cnt_q == (len_q - CNT_ONE))) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (in_cap_s) begin
         if (lat_cnt_q < LAT_MAX) begin
            lat_cnt_d = lat_cnt_q + LAT_ONE;
         end else begin
            lat_cnt_d = lat_cnt_q;
         end
         if (cap_act_s) begin
            cap_cnt_d = cap_cnt_q + CNT_ONE;
         end else begin
            cap_cnt_d = cap_cnt_q;
         end
      end else begin
         lat_cnt_d = lat_cnt_d;
      end

      // Abort overrides everything a running block would otherwise do
      if (abort_i && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         aborted_d = 1'b1;
         done_d    = done_q;
      end else begin
         aborted_d = aborted_d;
      end

      if (start_i && (state_q != ST_IDLE)) begin
         ovr_d = 1'b1;
      end else begin
         ovr_d = ovr_d;
      end
   end

   // State and counter registers
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= ST_IDLE;
         len_q      <= CNT_ZERO;
         feed_cnt_q <= CNT_ZERO;
         cap_cnt_q  <= CNT_ZERO;
         lat_cnt_q  <= {LW{1'b0}};
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         feed_cnt_q <= feed_cnt_d;
         cap_cnt_q  <= cap_cnt_d;
         lat_cnt_q  <= lat_cnt_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
         ovr_q      <= ovr_d;
      end
   end

   // Output decode from registered state; zero flush into the filter outside FEED
   always_comb begin
      x_rd_addr_o = in_feed_s ? feed_cnt_q[AW-1:0] : {AW{1'b0}};
      filt_in_o   = in_feed_s ? x_rd_data_i : {DW{1'b0}};
      filt_clr_o  = (state_q == ST_CLR);
      y_wr_en_o   = wr_fire_s;
      y_wr_addr_o = wr_fire_s ? cap_cnt_q[AW-1:0] : {AW{1'b0}};
      y_wr_data_o = wr_fire_s ? filt_out_i : {DW{1'b0}};
      busy_o      = (state_q != ST_IDLE);
      done_o      = done_q;
      aborted_o   = aborted_q;
      ovr_o       = ovr_q;
      int_o       = (state_q == ST_DONE) && !abort_i;
   end

endmodule

// File: tb/tb_iir_block_sequencer.sv
// Directed bench for iir_block_sequencer using a delay-line filter model and
// cycle-stamped monitors on the output buffer port and interrupt.
module tb_iir_block_sequencer;

   localparam int DW    = 32;
   localparam int NSAMP = 32;
   localparam int AW    = 5;
   localparam int PL    = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [AW:0]   len_i = '0;
   logic [AW-1:0] x_rd_addr_o;
   logic [DW-1:0] x_rd_data_i;
   logic [DW-1:0] filt_in_o;
   logic          filt_clr_o;
   logic [DW-1:0] filt_out_i;
   logic          y_wr_en_o;
   logic [AW-1:0] y_wr_addr_o;
   logic [DW-1:0] y_wr_data_o;
   logic          busy_o, done_o, aborted_o, ovr_o, int_o;

   logic [DW-1:0] x_mem [NSAMP];
   logic [DW-1:0] dl    [PL];
   logic [DW-1:0] y_mem [NSAMP];
   logic          wrote [NSAMP];

   int cyc = 0;
   int wr_cnt, first_wr, last_wr, int_cnt, int_cyc, clr_cyc;
   logic clr_req = 1'b0;
   int n_checks = 0;
   int n_errors = 0;

   iir_block_sequencer #(.DW(DW), .NSAMP(NSAMP), .AW(AW), .PIPE_LAT(PL), .CLR_ON_START(1)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .abort_i(abort_i), .len_i(len_i),
      .x_rd_addr_o(x_rd_addr_o), .x_rd_data_i(x_rd_data_i), .filt_in_o(filt_in_o),
      .filt_clr_o(filt_clr_o), .filt_out_i(filt_out_i), .y_wr_en_o(y_wr_en_o),
      .y_wr_addr_o(y_wr_addr_o), .y_wr_data_o(y_wr_data_o), .busy_o(busy_o), .done_o(done_o),
      .aborted_o(aborted_o), .ovr_o(ovr_o), .int_o(int_o)
   );

   always #5 clk = ~clk;

   assign x_rd_data_i = x_mem[x_rd_addr_o];
   assign filt_out_i  = dl[PL-1];

   // Filter stand-in: PL-deep delay line with synchronous clear
   always @(posedge clk or posedge rst) begin
      if (rst || filt_clr_o) begin
         for (int i = 0; i < PL; i++) dl[i] <= '0;
      end else begin
         dl[0] <= filt_in_o;
         for (int i = 1; i < PL; i++) dl[i] <= dl[i-1];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: output buffer writes, interrupt and clear pulses stamped with cycle number
   always @(posedge clk) begin
      if (clr_req) begin
         wr_cnt = 0; first_wr = -1; last_wr = -1; int_cnt = 0; int_cyc = -1; clr_cyc = -1;
         for (int i = 0; i < NSAMP; i++) begin y_mem[i] = '0; wrote[i] = 1'b0; end
      end else if (!rst) begin
         if (y_wr_en_o) begin
            y_mem[y_wr_addr_o] = y_wr_data_o;
            wrote[y_wr_addr_o] = 1'b1;
            if (wr_cnt == 0) first_wr = cyc;
            last_wr = cyc;
            wr_cnt++;
         end
         if (int_o) begin int_cnt++; int_cyc = cyc; end
         if (filt_clr_o) clr_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_blk(input logic [AW:0] len, output int s);
      len_i = len; start_i = 1'b1; clr_req = 1'b1; s = cyc;
      step();
      start_i = 1'b0; clr_req = 1'b0;
   endtask

   task automatic go(input int t);
      int g = 0;
      while (cyc < t && g < 1000) begin step(); g++; end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o && n < 300) begin step(); n++; end
      check("idle_timeout", 32'(n < 300), 32'd1);
      step(); step();
   endtask

   function automatic int bad_data(input int n);
      int bad = 0;
      for (int k = 0; k < n; k++) if (y_mem[k] !== 32'(k + 1)) bad++;
      return bad;
   endfunction

   task automatic check_full(input string tag, input int s);
      check({tag, "_wr_cnt"},   32'(wr_cnt),   32'd32);
      check({tag, "_first_wr"}, 32'(first_wr), 32'(s + 10));
      check({tag, "_last_wr"},  32'(last_wr),  32'(s + 41));
      check({tag, "_int_cnt"},  32'(int_cnt),  32'd1);
      check({tag, "_int_cyc"},  32'(int_cyc),  32'(s + 42));
      check({tag, "_done"},     32'(done_o),   32'd1);
      check({tag, "_aborted"},  32'(aborted_o), 32'd0);
      check({tag, "_data"},     32'(bad_data(32)), 32'd0);
   endtask

   initial begin
      int s;
      for (int k = 0; k < NSAMP; k++) x_mem[k] = 32'(k + 1);
      clr_req = 1'b1;
      step(); step(); step();
      clr_req = 1'b0;
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_flags", {29'd0, aborted_o, ovr_o, int_o}, 32'd0);
      check("rst_wr", {30'd0, y_wr_en_o, filt_clr_o}, 32'd0);
      check("rst_filt_in", filt_in_o, 32'd0);
      rst = 1'b0;
      step();

      start_blk(6'd32, s);
      check("t1_busy", 32'(busy_o), 32'd1);
      check("t1_clr", 32'(filt_clr_o), 32'd1);
      wait_idle();
      check_full("t1", s);
      check("t1_clr_cyc", 32'(clr_cyc), 32'(s + 1));

      start_blk(6'd3, s);
      wait_idle();
      check("t2_wr_cnt", 32'(wr_cnt), 32'd3);
      check("t2_first_wr", 32'(first_wr), 32'(s + 10));
      check("t2_last_wr", 32'(last_wr), 32'(s + 12));
      check("t2_int_cyc", 32'(int_cyc), 32'(s + 13));
      check("t2_addr3", 32'(wrote[3]), 32'd0);
      check("t2_data", 32'(bad_data(3)), 32'd0);

      start_blk(6'd0, s);
      wait_idle();
      check_full("t3_len0", s);
      start_blk(6'd40, s);
      wait_idle();
      check_full("t3_len40", s);

      start_blk(6'd32, s);
      go(s + 14);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      wait_idle();
      check("t4_wr_cnt", 32'(wr_cnt), 32'd4);
      check("t4_last_wr", 32'(last_wr), 32'(s + 13));
      check("t4_aborted", 32'(aborted_o), 32'd1);
      check("t4_done", 32'(done_o), 32'd0);
      check("t4_int_cnt", 32'(int_cnt), 32'd0);
      check("t4_data", 32'(bad_data(4)), 32'd0);
      start_blk(6'd32, s);
      wait_idle();
      check_full("t4_next", s);

      start_blk(6'd32, s);
      go(s + 7);
      len_i = 6'd3; start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("t5_ovr_set", 32'(ovr_o), 32'd1);
      wait_idle();
      check_full("t5", s);
      check("t5_ovr_hold", 32'(ovr_o), 32'd1);
      start_blk(6'd32, s);
      check("t5_ovr_clr", 32'(ovr_o), 32'd0);
      wait_idle();

      start_blk(6'd32, s);
      go(s + 12);
      check("t6_pre_wr", 32'(wr_cnt), 32'd2);
      rst = 1'b1;
      #1;
      check("t6_busy", 32'(busy_o), 32'd0);
      check("t6_wr", {29'd0, y_wr_en_o, filt_clr_o, int_o}, 32'd0);
      check("t6_addr", {22'd0, x_rd_addr_o, y_wr_addr_o}, 32'd0);
      check("t6_data", filt_in_o | y_wr_data_o, 32'd0);
      check("t6_flags", {29'd0, done_o, aborted_o, ovr_o}, 32'd0);
      step();
      rst = 1'b0; clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (50) step();
      check("t6_no_wr", 32'(wr_cnt), 32'd0);
      check("t6_no_int", 32'(int_cnt), 32'd0);
      check("t6_idle", 32'(busy_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
